// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/operand/result bundle between controlUnit (master) and mult_div_unit (slave)
// Signals: multOP/divOP start pulses, A/B operands, hi/lo results, busy/done/divZero status.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             multOP;
  logic             divOP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divZero;
  modport master (output multOP, divOP, A, B, input hi, lo, busy, done, divZero);
  modport slave (input multOP, divOP, A, B, output hi, lo, busy, done, divZero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiplier / restoring divider with HI/LO result registers
// Ports: clk, reset (sync, active-high); bus (slave): multOP/divOP start pulses, A/B operands,
//   hi/lo results, busy (not IDLE), done (1-cycle result pulse), divZero (1-cycle div-by-zero pulse).
// Config: MULTDIV_DIVZERO_EXC_EN defined -> divide by zero finishes in one edge with divZero=1
//   and hi/lo untouched; undefined -> divZero tied low and the division runs to completion.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH:0]     p_q;
  logic                 dz_q;
  logic                 start, last, dz_start;
  logic [WIDTH-1:0]     amag_in, bmag, rem, quo, hi_fix, lo_fix;
  logic [WIDTH:0]       addend, sum, sh;
  logic                 ge;
  logic [2*WIDTH:0]     p_mult, p_div;
  assign start = bus.multOP | bus.divOP;
  assign last  = cnt_q == CW'(1);
`ifdef MULTDIV_DIVZERO_EXC_EN
  assign dz_start = bus.B == '0;
`else
  assign dz_start = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.multOP ? MULT : bus.divOP ? (dz_start ? DONE : DIV) : IDLE;
      MULT:    state_d = last ? DONE : MULT;
      DIV:     state_d = last ? FIX : DIV;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy    = state_q != IDLE;
    bus.done    = state_q == DONE;
    bus.divZero = (state_q == DONE) & dz_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
  end
  // Booth step: the upper half is widened to WIDTH+1 bits so -A of the most negative A is exact.
  always_comb begin
    addend = p_q[1:0] == 2'b01 ? {a_q[WIDTH-1], a_q} :
             p_q[1:0] == 2'b10 ? -{a_q[WIDTH-1], a_q} : '0;
    sum    = {p_q[2*WIDTH], p_q[2*WIDTH:WIDTH+1]} + addend;
    p_mult = {sum, p_q[WIDTH:1]};
  end
  // Restoring step: remainder in p_q[2W-1:W], dividend/quotient shifting through p_q[W-1:0].
  always_comb begin
    amag_in = bus.A[WIDTH-1] ? -bus.A : bus.A;
    bmag    = b_q[WIDTH-1] ? -b_q : b_q;
    sh      = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge      = sh >= {1'b0, bmag};
    p_div   = {1'b0, ge ? WIDTH'(sh - {1'b0, bmag}) : sh[WIDTH-1:0], p_q[WIDTH-2:0], ge};
    rem     = p_q[2*WIDTH-1:WIDTH];
    quo     = p_q[WIDTH-1:0];
    hi_fix  = a_q[WIDTH-1] ? -rem : rem;
    lo_fix  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo;
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= bus.A;
          b_q   <= bus.B;
          cnt_q <= CW'(WIDTH);
          p_q   <= bus.multOP ? {{WIDTH{1'b0}}, bus.B, 1'b0} : {{(WIDTH+1){1'b0}}, amag_in};
          dz_q  <= ~bus.multOP & dz_start;
        end
        MULT: begin
          p_q   <= p_mult;
          cnt_q <= cnt_q - CW'(1);
          if (last) {hi_q, lo_q} <= p_mult[2*WIDTH:1];
        end
        DIV: begin
          p_q   <= p_div;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end
endmodule
